// File: rtl/sd_1011_mealy.sv
// ---------------------------------------------------------------------------
// sd_1011_mealy
//
// Serial pattern detector (Mealy FSM) for the bit sequence 1-0-0-1, where the
// first bit received is the first bit of the pattern. One bit is consumed per
// rising clock edge. The detect flag is combinational, so it asserts in the
// same cycle as the final 1 of the pattern.
//
// Configuration macro: SD_1011_MEALY_OVERLAP_EN
//   defined     : overlapping detection (the final 1 of a match may start the
//                 next match, so 1001001 detects twice)
//   not defined : non-overlapping detection (a completed match restarts from
//                 idle, so 1001001 detects once)
//
// Ports:
//   clk   in   1  rising-edge clock
//   reset in   1  synchronous, active-low; returns the FSM to idle
//   din   in   1  serial data bit, consumed at each rising edge
//   dout  out  1  detect flag; combinational in state and din, forced low
//                 while reset is low
// ---------------------------------------------------------------------------
module sd_1011_mealy (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  // Match-progress states, named after the prefix of 1001 matched so far.
  localparam logic [1:0] S0   = 2'b00;
  localparam logic [1:0] S1   = 2'b01;
  localparam logic [1:0] S10  = 2'b10;
  localparam logic [1:0] S100 = 2'b11;

  logic [1:0] state_r;
  logic [1:0] next_state_s;

  // State register with synchronous active-low reset back to idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: track the longest pattern prefix that is a suffix of
  // the stream seen so far.
  always_comb begin
    next_state_s = S0;
    case (state_r)
      S0: begin
        if (din) begin
          next_state_s = S1;
        end else begin
          next_state_s = S0;
        end
      end
      S1: begin
        // A run of leading 1s keeps us waiting for the first 0.
        if (din) begin
          next_state_s = S1;
        end else begin
          next_state_s = S10;
        end
      end
      S10: begin
        if (din) begin
          next_state_s = S1;
        end else begin
          next_state_s = S100;
        end
      end
      S100: begin
        if (din) begin
`ifdef SD_1011_MEALY_OVERLAP_EN
          // The completing 1 doubles as the first 1 of the next pattern.
          next_state_s = S1;
`else
          // Completed match is consumed entirely; start over.
          next_state_s = S0;
`endif
        end else begin
          // "1000" has no suffix that is a prefix of 1001.
          next_state_s = S0;
        end
      end
      default: begin
        next_state_s = S0;
      end
    endcase
  end

  // Mealy output decode; reset masks the flag immediately, not just at the
  // next edge.
  always_comb begin
    dout = 1'b0;
    if (reset && (state_r == S100) && din) begin
      dout = 1'b1;
    end else begin
      dout = 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_1011_mealy.sv
// ---------------------------------------------------------------------------
// Testbench for sd_1011_mealy. Stimulus pushes the expected detect flag for
// each cycle into a scoreboard queue; an independent monitor pops and compares
// on every falling clock edge. The reference model keeps the raw bit history
// since the last reset (or since the last match in the non-overlap build) and
// flags a detect when the last four bits read 1,0,0,1.
// ---------------------------------------------------------------------------
module tb_sd_1011_mealy;

  logic clk;
  logic reset;
  logic din;
  logic dout;

  int compared;
  int mismatched;

  bit    exp_q[$];
  string name_q[$];

  // Reference model state: recent bits, oldest first.
  int hist[$];

  sd_1011_mealy dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compute the expected flag for the current cycle's inputs and update the
  // history as the edge will.
  function automatic bit model_step(input bit rst, input bit d);
    bit hit;
    hit = 1'b0;
    if (!rst) begin
      hist.delete();
    end else begin
      hist.push_back(int'(d));
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] == 1 && hist[1] == 0 &&
          hist[2] == 0 && hist[3] == 1) begin
        hit = 1'b1;
`ifndef SD_1011_MEALY_OVERLAP_EN
        hist.delete();
`endif
      end
    end
    return hit;
  endfunction

  // Drive one cycle of inputs just after the rising edge and log expectation.
  task automatic apply(input bit rst, input bit d, input string nm);
    @(posedge clk);
    #1;
    reset = rst;
    din   = d;
    exp_q.push_back(model_step(rst, d));
    name_q.push_back(nm);
  endtask

  task automatic apply_stream(input bit bits[], input string nm);
    foreach (bits[i]) apply(1'b1, bits[i], $sformatf("%s[%0d]", nm, i + 1));
  endtask

  // Monitor: compare the DUT flag against the scoreboard mid-cycle.
  always @(negedge clk) begin
    bit    e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      compared++;
      if (dout !== e) begin
        mismatched++;
        $display("FAIL %s: dout=%0b expected=%0b", n, dout, e);
      end
    end
  end

  initial begin
    bit s2[];
    bit s4[];
    int budget;
    compared   = 0;
    mismatched = 0;
    reset = 1'b0;
    din   = 1'b0;

    // Reset held with din=1, then 0,0,1 must not detect.
    apply(1'b0, 1'b1, "rst_hold1");
    apply(1'b0, 1'b1, "rst_hold2");
    apply(1'b1, 1'b0, "post_rst0a");
    apply(1'b1, 1'b0, "post_rst0b");
    apply(1'b1, 1'b1, "post_rst1");

    // Overlap check stream (two detects overlap build, one otherwise).
    apply(1'b0, 1'b0, "rst_s2");
    s2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_stream(s2, "s2");

    // Near-miss fragments 101 and 000.
    apply(1'b0, 1'b0, "rst_s4");
    s4 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_stream(s4, "s4");

    // Reset mid-pattern discards the partial match.
    apply(1'b0, 1'b0, "rst_s5");
    apply(1'b1, 1'b1, "s5_1");
    apply(1'b1, 1'b0, "s5_0a");
    apply(1'b1, 1'b0, "s5_0b");
    apply(1'b0, 1'b1, "s5_rst");
    apply(1'b1, 1'b1, "s5_after");

    // Random stream with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      apply(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
            $sformatf("rand[%0d]", i));
    end

    // Drain the scoreboard within a bounded number of cycles.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sd_1011_mealy.md
# sd_1011_mealy

Serial bit-pattern detector built as a Mealy FSM. It watches a 1-bit input stream sampled once per clock and asserts a detect flag for the pattern 1-0-0-1 (first bit received first). Detection overlaps by default. The block is a leaf: one input bit per cycle in, one combinational detect flag out, for use by downstream control logic.

## Interface
Parameters:
- None. The pattern is fixed at 1001.

Ports:
- `clk`  input  1  Single clock. All state updates happen on the rising edge.
- `reset`  input  1  Reset is synchronous and active-low. When `reset` is 0 at a rising edge of `clk`, the FSM returns to its idle state.
- `din`  input  1  Serial data bit. The FSM consumes it at each rising edge.
- `dout`  output  1  Detect flag. It is a Mealy output, a combinational function of the current state and `din`.

## Operation
- States (2-bit encoding, binary):
  - S0 = idle / nothing matched
  - S1 = "1" matched
  - S10 = "10" matched
  - S100 = "100" matched
- Transitions, written as current state, then the `din` value → next state:
  - S0: 0 → S0, 1 → S1
  - S1: 1 → S1, 0 → S10
  - S10: 1 → S1, 0 → S100
  - S100: 0 → S0, 1 → S1 (overlap: the final 1 becomes the first 1 of the next pattern)
- `dout` = 1 if and only if the state is S100, `din` = 1, and `reset` = 1. Otherwise `dout` = 0.
- Output decode is purely combinational. The state register is the only storage.
- Reset:
  - When `reset` = 0 at a rising edge, the next state is S0 regardless of `din`.
  - `dout` is forced to 0 for as long as `reset` is low.
- Reset in the middle of a pattern discards any partial match. Matching restarts from S0 on the first edge where `reset` = 1.
- Before the first reset edge the state is undefined. The environment must apply reset before relying on `dout`.

## Timing
- Latency is zero cycles. `dout` rises in the same cycle the final 1 of the pattern is presented on `din`, before the edge that consumes it.
- `dout` is high for exactly one cycle per match, provided `din` is stable for the whole cycle.
- `dout` may glitch if `din` changes mid-cycle. Consumers must sample `dout` on the rising edge of `clk`.
- The state register updates only on the rising edge of `clk`.
- Reset value of every output: `dout` = 0.
- The minimum spacing between overlapping matches is 3 cycles (1001001 yields two detects).
- A run of leading 1s stays in S1. For example, 11001 detects once, on the final 1.

## Configuration
- Macro: `SD_1011_MEALY_OVERLAP_EN`.
- Defined (default build): overlapping detection, with S100 + 1 → S1 as listed above.
- Not defined: non-overlapping detection.
  - S100 + 1 → S0. `dout` is still 1 in that cycle.
  - The bits of a completed match cannot start the next match. For example, 1001001 detects only once.
- All other transitions, the reset behaviour and the output timing are identical in both builds.

## Test plan
1. Hold `reset` = 0 for 2 edges with `din` = 1 → `dout` = 0 throughout. The state is S0 after release, so a following 0,0,1 produces no detect.
2. After reset, `din` stream 0,0,1,0,0,1,0,0,1 (overlap build) → `dout` = 1 only during bits 6 and 9, exactly one cycle each.
3. Same stream in the non-overlap build → `dout` = 1 only during bit 6.
4. Stream 1,1,0,0,1,0,1,0,0,0,1 → `dout` = 1 only during bit 5. The 1-0-1 and 0-0-0 fragments must not trigger a detect.
5. Stream 1,0,0, then `reset` = 0 for 1 edge, then 1 → `dout` = 0 during the reset cycle and 0 on the following 1.
6. Random 1000-bit stream compared against a 4-bit shift-register golden model that implements the same overlap rule for the build under test → `dout` matches the model every cycle.
